// File: rtl/merge_cfg_ctrl.sv
// Runtime configuration controller for the merge network: stages per-router config words in
// shadow registers and swaps them into the active vectors once the network has drained.
module merge_cfg_ctrl #(
  parameter int unsigned NOC_WIDTH     = 3,
  parameter int unsigned NOC_HEIGHT    = 3,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  localparam int unsigned NR           = NOC_WIDTH * NOC_HEIGHT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     cfg_data_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [NR-1:0]   net_busy_i,
  output logic            inject_hold_o,
  output logic [NR*5-1:0] input_mask_o,
  output logic [NR*3-1:0] output_sel_o,
  output logic            cfg_done_o,
  output logic            cfg_err_o
);

  localparam int unsigned DcW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TcW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DcW-1:0] DcMax = DcW'(DRAIN_CYCLES);
  localparam logic [TcW-1:0] TcMax = TcW'(DRAIN_TIMEOUT);
  localparam logic [6:0] NrIdx = 7'(NR);

  typedef enum logic [1:0] {StIdle, StDrain, StApply, StRelease} state_e;

  state_e state_q, state_d;
  logic [DcW-1:0]  dcnt_q, dcnt_d;
  logic [TcW-1:0]  tcnt_q, tcnt_d;
  logic [NR*5-1:0] act_mask_q, act_mask_d, sh_mask_q, sh_mask_d;
  logic [NR*3-1:0] act_sel_q, act_sel_d, sh_sel_q, sh_sel_d;
  logic            ready_q, ready_d, hold_q, hold_d;
  logic            done_q, done_d, err_q, err_d;

  logic       cfg_commit;
  logic [6:0] cfg_idx;
  logic [4:0] cfg_mask;
  logic [2:0] cfg_sel;

  assign cfg_commit = cfg_data_i[15];
  assign cfg_idx    = cfg_data_i[14:8];
  assign cfg_mask   = cfg_data_i[7:3];
  assign cfg_sel    = cfg_data_i[2:0];

  always_comb begin
    state_d    = state_q;
    dcnt_d     = '0;
    tcnt_d     = '0;
    act_mask_d = act_mask_q;
    act_sel_d  = act_sel_q;
    sh_mask_d  = sh_mask_q;
    sh_sel_d   = sh_sel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i && ready_q) begin
          if (cfg_idx < NrIdx) begin
            for (int unsigned r = 0; r < NR; r++) begin
              if (cfg_idx == 7'(r)) begin
                sh_mask_d[r*5 +: 5] = cfg_mask;
                sh_sel_d[r*3 +: 3]  = cfg_sel;
              end
            end
          end else begin
            err_d = 1'b1;
          end
          if (cfg_commit) state_d = StDrain;
        end
      end
      StDrain: begin
        dcnt_d = (|net_busy_i) ? '0 : ((dcnt_q == DcMax) ? dcnt_q : dcnt_q + 1'b1);
        tcnt_d = (tcnt_q == TcMax) ? tcnt_q : tcnt_q + 1'b1;
        // A drain that completes on the timeout cycle still counts as success.
        if (dcnt_d == DcMax) begin
          state_d = StApply;
        end else if (tcnt_d == TcMax) begin
          sh_mask_d = act_mask_q;
          sh_sel_d  = act_sel_q;
          err_d     = 1'b1;
          state_d   = StRelease;
        end
      end
      StApply: begin
        act_mask_d = sh_mask_q;
        act_sel_d  = sh_sel_q;
        done_d     = 1'b1;
        state_d    = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    hold_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dcnt_q     <= '0;
      tcnt_q     <= '0;
      act_mask_q <= '0;
      act_sel_q  <= '0;
      sh_mask_q  <= '0;
      sh_sel_q   <= '0;
      ready_q    <= 1'b1;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      tcnt_q     <= tcnt_d;
      act_mask_q <= act_mask_d;
      act_sel_q  <= act_sel_d;
      sh_mask_q  <= sh_mask_d;
      sh_sel_q   <= sh_sel_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready_o   = ready_q;
  assign inject_hold_o = hold_q;
  assign input_mask_o  = act_mask_q;
  assign output_sel_o  = act_sel_q;
  assign cfg_done_o    = done_q;
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_merge_cfg_ctrl.sv
// Directed bench for merge_cfg_ctrl: staging, drain/glitch, bad index, timeout, held valid and
// reset during apply, all against hand-computed expected vectors.
module tb_merge_cfg_ctrl;

  localparam int unsigned NR = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NR-1:0] net_busy;
  logic          inject_hold;
  logic [44:0]   input_mask;
  logic [26:0]   output_sel;
  logic          cfg_done;
  logic          cfg_err;

  int vectors = 0;
  int miscompares = 0;

  merge_cfg_ctrl #(
    .NOC_WIDTH    (3),
    .NOC_HEIGHT   (3),
    .DRAIN_CYCLES (4),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_data_i   (cfg_data),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .net_busy_i   (net_busy),
    .inject_hold_o(inject_hold),
    .input_mask_o (input_mask),
    .output_sel_o (output_sel),
    .cfg_done_o   (cfg_done),
    .cfg_err_o    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] word);
    cfg_data  = word;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Called in cycle 1 after a commit; ends in cycle end_at+1 (back in idle).
  task automatic drain_run(input int busy_last, input int glitch_at, input int done_at,
                           input int err_at, input int end_at,
                           input logic [44:0] exp_m, input logic [26:0] exp_s);
    for (int k = 1; k <= end_at; k++) begin
      net_busy = ((k <= busy_last) || (k == glitch_at)) ? 9'h008 : 9'h000;
      chk($sformatf("done@%0d", k), cfg_done, (k == done_at));
      chk($sformatf("err@%0d", k), cfg_err, (k == err_at));
      chk($sformatf("hold@%0d", k), inject_hold, 1'b1);
      chk($sformatf("ready@%0d", k), cfg_ready, 1'b0);
      if (k == end_at) begin
        chk("mask_end", input_mask, exp_m);
        chk("sel_end", output_sel, exp_s);
      end
      step();
    end
    net_busy = '0;
    chk("hold_rel", inject_hold, 1'b0);
    chk("ready_rel", cfg_ready, 1'b1);
    chk("done_rel", cfg_done, 1'b0);
    chk("err_rel", cfg_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_data = '0; cfg_valid = 1'b0; net_busy = '0;
    step(); step();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_hold", inject_hold, 1'b0);
    chk("rst_mask", input_mask, 45'h0);
    chk("rst_sel", output_sel, 27'h0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    rst = 1'b0;
    step();

    // Basic stage + commit, idle network: done at commit+6.
    send(16'h046A);
    send(16'h800C);
    drain_run(0, 0, 6, 0, 6, 45'h0000_00D0_0001, 27'h000_2004);

    // Busy for 10 cycles, then 4 idle cycles.
    net_busy = 9'h008;
    send(16'h8181);
    drain_run(10, 0, 16, 0, 16, 45'h0000_00D0_0201, 27'h000_200C);

    // Busy glitch when the drain count is 3 restarts the count.
    send(16'h88FF);
    drain_run(1, 5, 11, 0, 11, 45'h1F00_00D0_0201, 27'h700_200C);

    // Bad index dropped with an error pulse; bad-index commit applies valid staging only.
    send(16'h09AB);
    chk("bad_err", cfg_err, 1'b1);
    chk("bad_ready", cfg_ready, 1'b1);
    chk("bad_mask", input_mask, 45'h1F00_00D0_0201);
    step();
    chk("bad_err_clr", cfg_err, 1'b0);
    send(16'h0235);
    send(16'h8900);
    drain_run(0, 0, 6, 1, 6, 45'h1F00_00D0_1A01, 27'h700_214C);

    // Timeout: network never drains, staged writes discarded.
    send(16'h0309);
    send(16'h8512);
    drain_run(100, 0, 0, 17, 17, 45'h1F00_00D0_1A01, 27'h700_214C);
    send(16'h8900);
    drain_run(0, 0, 6, 1, 6, 45'h1F00_00D0_1A01, 27'h700_214C);

    // Word held valid through DRAIN is taken only once back in idle.
    send(16'h861B);
    cfg_data  = 16'h0726;
    cfg_valid = 1'b1;
    drain_run(0, 0, 6, 0, 6, 45'h1F00_C0D0_1A01, 27'h70C_214C);
    step();
    cfg_valid = 1'b0;
    chk("held_ready", cfg_ready, 1'b1);
    chk("held_hold", inject_hold, 1'b0);
    send(16'h8900);
    drain_run(0, 0, 6, 1, 6, 45'h1F20_C0D0_1A01, 27'h7CC_214C);

    // Reset asserted in the APPLY cycle.
    send(16'h80FF);
    step(); step(); step(); step();
    chk("apply_hold", inject_hold, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstap_mask", input_mask, 45'h0);
    chk("rstap_sel", output_sel, 27'h0);
    chk("rstap_hold", inject_hold, 1'b0);
    chk("rstap_ready", cfg_ready, 1'b1);
    chk("rstap_done", cfg_done, 1'b0);
    step();
    chk("rstap_done2", cfg_done, 1'b0);
    // Shadow must be cleared too.
    send(16'h8900);
    drain_run(0, 0, 6, 1, 6, 45'h0, 27'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
